// File: rtl/mmu_codec_pkg.sv
// rtl/mmu_codec_pkg.sv - shared types and constants for the codec register bridge
package mmu_codec_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 24;

    localparam int ERR_OVF = 0;
    localparam int ERR_TMO = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/codec_cmd_fifo.sv
// rtl/codec_cmd_fifo.sv - first-word-fall-through command FIFO of {addr,data} entries
module codec_cmd_fifo
    import mmu_codec_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Caller only pushes when space exists (or a pop frees it) and only pops when non-empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

    // The extra pointer bit makes full and empty distinguishable with exact wrap.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[PW-1:0]];
endmodule

// File: rtl/mmu_codec_bridge.sv
// rtl/mmu_codec_bridge.sv - CPU-to-codec register bridge: command FIFO, ce/ack drain FSM, errors
// Define CODEC_RDBACK_EN to build the shadow register file returning last writes on CPU reads.
module mmu_codec_bridge
    import mmu_codec_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_en_codec,
    input  logic              CPU_rw,
    input  logic [ADDR_W-1:0] CPU_addr,
    input  logic [DATA_W-1:0] din_mmu,
    output logic [DATA_W-1:0] dout_mmu,
    output logic              codec_ce,
    output logic [ADDR_W-1:0] codec_addr,
    output logic [DATA_W-1:0] codec_data,
    input  logic              codec_ack,
    output logic              busy,
    output logic              full,
    output logic [1:0]        err,
    input  logic              err_clr
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                   state;
    logic [TW-1:0]            timer;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CW-1:0]            count;
    logic                     empty;
    logic                     wr_req;
    logic                     push;
    logic                     pop;
    logic                     ack_pop;
    logic                     tmo_pop;

    assign wr_req  = CPU_en_codec & ~CPU_rw;
    assign ack_pop = (state == WAIT) & codec_ack;
    assign tmo_pop = (state == WAIT) & ~codec_ack & (timer == TW'(ACK_TIMEOUT));
    assign pop     = ack_pop | tmo_pop;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push    = wr_req & (~full | pop);

    codec_cmd_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata({CPU_addr, din_mmu}),
        .head (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    assign busy = (count != '0) | (state != IDLE);

    // timer counts cycles since codec_ce rose; expiry leaves ce high ACK_TIMEOUT+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            codec_ce   <= 1'b0;
            codec_addr <= '0;
            codec_data <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {codec_addr, codec_data} <= head;
                        codec_ce <= 1'b1;
                        timer    <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (pop) begin
                        codec_ce <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    codec_ce <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Set events win over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            err[ERR_OVF] <= (err[ERR_OVF] & ~err_clr) | (wr_req & ~push);
            err[ERR_TMO] <= (err[ERR_TMO] & ~err_clr) | tmo_pop;
        end
    end

`ifdef CODEC_RDBACK_EN
    logic [DATA_W-1:0] shadow [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) shadow[i] <= '0;
            dout_mmu <= '0;
        end else begin
            if (push) shadow[CPU_addr] <= din_mmu;
            if (CPU_en_codec & CPU_rw) dout_mmu <= shadow[CPU_addr];
        end
    end
`else
    assign dout_mmu = '0;
`endif
endmodule

// File: tb/tb_mmu_codec_bridge.sv
// tb/tb_mmu_codec_bridge.sv - self-checking bench for mmu_codec_bridge with a transaction-level model
module tb_mmu_codec_bridge;
    localparam int AW = 4;
    localparam int DW = 24;
    localparam int DEPTH = 8;
    localparam int TO = 4;
`ifdef CODEC_RDBACK_EN
    localparam bit RDBACK = 1'b1;
`else
    localparam bit RDBACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CPU_en_codec = 1'b0;
    logic          CPU_rw = 1'b0;
    logic [AW-1:0] CPU_addr = '0;
    logic [DW-1:0] din_mmu = '0;
    logic [DW-1:0] dout_mmu;
    logic          codec_ce;
    logic [AW-1:0] codec_addr;
    logic [DW-1:0] codec_data;
    logic          codec_ack = 1'b0;
    logic          busy;
    logic          full;
    logic [1:0]    err;
    logic          err_clr = 1'b0;

    mmu_codec_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .CPU_en_codec(CPU_en_codec), .CPU_rw(CPU_rw),
        .CPU_addr(CPU_addr), .din_mmu(din_mmu), .dout_mmu(dout_mmu),
        .codec_ce(codec_ce), .codec_addr(codec_addr), .codec_data(codec_data),
        .codec_ack(codec_ack), .busy(busy), .full(full), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    shadow_m [2**AW];
    logic [1:0]       exp_err = 2'b00;
    bit               in_flight = 0;
    bit               ign_len = 0;
    bit               stable = 0;
    bit               early = 0;
    int               ce_cycles = 0;
    int               ack_at = 0;
    int               ack_mode = 0;
    int               ack_at_cfg = 2;
    int               n_issued = 0;
    logic [AW+DW-1:0] cur;
    logic [AW+DW-1:0] exp_cmd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int occ();
        return exp_q.size() + int'(in_flight);
    endfunction

    // True while the current cycle ends in a FIFO pop (acked in WAIT, or timer expiry).
    function automatic bit pop_now();
        return in_flight && ((codec_ack && ce_cycles >= 2) || ce_cycles == TO + 1);
    endfunction

    function automatic logic [DW-1:0] rd_exp(input logic [AW-1:0] a);
        return RDBACK ? shadow_m[a] : '0;
    endfunction

    // Codec responder and command scoreboard; ack_mode 0=never, 1=fixed cycle, 2=random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (codec_ce) begin
                ce_cycles++;
                if (ce_cycles == 1) begin
                    ack_at = (ack_mode == 1) ? ack_at_cfg :
                             (ack_mode == 2) ? int'($urandom_range(2, TO + 2)) : 99;
                    early = (ack_mode == 2) && ($urandom_range(0, 3) == 0);
                    n_issued++;
                    check("cmd_pending", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_cmd = exp_q.pop_front();
                        check("cmd", 32'({codec_addr, codec_data}), 32'(exp_cmd));
                    end
                    cur = {codec_addr, codec_data};
                    in_flight = 1;
                    stable = 1;
                end else if ({codec_addr, codec_data} !== cur) begin
                    stable = 0;
                end
                codec_ack = (ce_cycles == ack_at) || (early && ce_cycles == 1);
            end else begin
                if (ce_cycles != 0 && !ign_len) begin
                    check("ce_len", ce_cycles, (ack_at <= TO + 1) ? ack_at : TO + 1);
                    check("cmd_stable", 32'(stable), 1);
                    if (ack_at > TO + 1) exp_err[1] = 1'b1;
                end
                ce_cycles = 0;
                in_flight = 0;
                codec_ack = 1'b0;
            end
        end
    end

    // All CPU tasks start and end on a falling edge.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        acc = (occ() < DEPTH) || pop_now();
        CPU_en_codec = 1'b1; CPU_rw = 1'b0; CPU_addr = a; din_mmu = d;
        if (acc) begin
            exp_q.push_back({a, d});
            shadow_m[a] = d;
        end else begin
            exp_err[0] = 1'b1;
        end
        @(negedge clk);
        CPU_en_codec = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input string tag);
        CPU_en_codec = 1'b1; CPU_rw = 1'b1; CPU_addr = a;
        @(negedge clk);
        CPU_en_codec = 1'b0; CPU_rw = 1'b0;
        check(tag, 32'(dout_mmu), 32'(rd_exp(a)));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        exp_err = 2'b00;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || in_flight) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < 400), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(occ() != 0));
        check({tag, "_full"}, 32'(full), 32'(occ() == DEPTH));
        check({tag, "_err"},  32'(err),  32'(exp_err));
    endtask

    initial begin
        int  k;
        bit  hit;
        int  op;
        for (int i = 0; i < 2**AW; i++) shadow_m[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dout", 32'(dout_mmu), 0);
        check("rst_ce", 32'(codec_ce), 0);
        check("rst_addr", 32'(codec_addr), 0);
        check("rst_data", 32'(codec_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);

        // Single write, ack in the third ce cycle.
        ack_mode = 1; ack_at_cfg = 3;
        cpu_write(4'd3, 24'hABCDEF);
        check("t1_ce_n1", 32'(codec_ce), 0);
        @(negedge clk);
        check("t1_ce_n2", 32'(codec_ce), 1);
        check("t1_addr", 32'(codec_addr), 3);
        check("t1_data", 32'(codec_data), 32'h00ABCDEF);
        repeat (4) @(negedge clk);
        check("t1_busy", 32'(busy), 0);
        check("t1_err", 32'(err), 0);
        check("t1_ce_low", 32'(codec_ce), 0);

        // Back-to-back pushes with no ack: one timeout drain, then overflow on the tenth.
        ack_mode = 0;
        for (int i = 0; i < 10; i++) cpu_write(AW'(i), 24'($urandom));
        check("t2_full", 32'(full), 1);
        check("t2_ovf", 32'(err[0]), 1);
        check_state("t2");
        ack_mode = 1; ack_at_cfg = 2;
        wait_idle("t2_drain");
        clear_err();
        check("t2_clr", 32'(err), 0);

        // Timeouts: ce held ACK_TIMEOUT+1 cycles, then the next command goes out.
        ack_mode = 0;
        cpu_write(4'd7, 24'h111111);
        cpu_write(4'd8, 24'h222222);
        wait_idle("t3_drain");
        check("t3_err", 32'(err), 32'h2);
        clear_err();
        check("t3_clr", 32'(err), 0);

        // Push at full coinciding with an ack-driven pop.
        ack_mode = 1; ack_at_cfg = 5;
        k = 0;
        while (!full && k < 40) begin
            cpu_write(AW'($urandom), 24'($urandom));
            k++;
        end
        check("t4_full_pre", 32'(full), 1);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (pop_now() && codec_ack) begin
                cpu_write(4'd9, 24'h0F0F0F);
                hit = 1;
            end else begin
                @(negedge clk);
            end
        end
        check("t4_hit", 32'(hit), 1);
        check("t4_full_post", 32'(full), 1);
        check("t4_err", 32'(err), 0);
        wait_idle("t4_drain");

        // Shadow readback.
        cpu_write(4'd5, 24'h123456);
        cpu_read(4'd5, "t5_rd5");
        check("t5_rd5_const", 32'(dout_mmu), RDBACK ? 32'h00123456 : 32'h0);
        cpu_read(4'd6, "t5_rd6");
        wait_idle("t5_drain");

        // Randomized traffic against the model.
        ack_mode = 2;
        for (int it = 0; it < 250; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5)      cpu_write(AW'($urandom), 24'($urandom));
            else if (op < 7) cpu_read(AW'($urandom), "rnd_rd");
            else if (op < 9) @(negedge clk);
            else             clear_err();
            check_state("rnd");
        end
        ack_mode = 1; ack_at_cfg = 2;
        wait_idle("rnd_drain");

        // Reset in WAIT with commands queued.
        clear_err();
        ack_mode = 0;
        for (int i = 0; i < 4; i++) cpu_write(AW'(i + 10), 24'($urandom));
        k = 0;
        while (ce_cycles < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_wait", 32'(ce_cycles >= 2), 1);
        ign_len = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_err = 2'b00;
        for (int i = 0; i < 2**AW; i++) shadow_m[i] = '0;
        check("t6_ce", 32'(codec_ce), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_full", 32'(full), 0);
        check("t6_err", 32'(err), 0);
        k = n_issued;
        repeat (20) @(negedge clk);
        check("t6_no_cmd", n_issued, k);
        ign_len = 0;
        cpu_read(4'd6, "t6_rd6");
        check("t6_rd6_zero", 32'(dout_mmu), 0);
        cpu_read(4'd12, "t6_rd12");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
